ifetch_unit: RTL and testbench
==============================

Name: ifetch_unit

Overview:
Instruction-fetch stage directly downstream of the PC register. Takes the current PC value and issues a read to instruction memory over a request/grant/response handshake. Latches the returned word into an instruction register for decode and produces the one-cycle `pc_advance` strobe that enables the PC register to step. Handles branch flushes, misaligned PCs and a delivered-instruction counter.

Parameters:
RESET_PC, 32'h00400020, value of `mem_addr` while in reset; matches the PC register's start address
CNT_W, 16, width of the delivered-instruction counter

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  asynchronous active-low reset
pc_in  in  32  current PC from the PC register; must be stable by the rising edge following any `pc_advance` or `flush`
flush  in  1  branch taken / redirect; discard any in-flight or held instruction
mem_req  out  1  instruction-memory read request
mem_addr  out  32  registered read address
mem_gnt  in  1  memory accepted the request (sampled only while `mem_req`=1)
mem_rvalid  in  1  read data valid; never asserted in the same cycle as its `mem_gnt`
mem_rdata  in  32  read data
instr_out  out  32  instruction register
instr_pc  out  32  address `instr_out` was fetched from
instr_valid  out  1  `instr_out` is valid for decode
stall_in  in  1  decode cannot accept this cycle
pc_advance  out  1  one-cycle strobe; PC register steps on it
fetch_err  out  1  sticky misaligned-PC error
fetch_count  out  CNT_W  count of delivered instructions

Behaviour:
- Reset (async, any state, mid-transaction included):
  - state=IDLE, `mem_req`=0, `mem_addr`=RESET_PC, `instr_out`=0, `instr_pc`=0, `instr_valid`=0, `pc_advance`=0, `fetch_err`=0, `fetch_count`=0.
  - Any response still outstanding at reset is the memory's responsibility; after reset `mem_rvalid` is ignored until a new grant.
- States: IDLE, REQ, WAIT, HOLD, DROP, ERR.
- IDLE: on the first edge after reset release, capture `pc_in`.
  - `pc_in[1:0]`≠0 -> ERR with `fetch_err`=1.
  - Otherwise `mem_addr`<=`pc_in`, `mem_req`<=1, go to REQ.
- REQ: hold `mem_req`=1 and `mem_addr` stable until `mem_gnt`=1.
  - `mem_gnt` and no flush -> WAIT, `mem_req`<=0.
  - flush without `mem_gnt` -> stay REQ; recapture `pc_in` on the next edge (alignment checked again).
  - flush with `mem_gnt` -> DROP, `mem_req`<=0.
- WAIT: on `mem_rvalid`, `instr_out`<=`mem_rdata`, `instr_pc`<=`mem_addr`, `instr_valid`<=1, go to HOLD.
  - flush before `mem_rvalid` -> DROP.
  - flush in the same cycle as `mem_rvalid` -> data discarded, `instr_valid` stays 0, next state is a recapture of `pc_in` (IDLE-style capture, one cycle).
- HOLD: `instr_valid`=1.
  - While `stall_in`=1, all outputs hold.
  - First cycle with `stall_in`=0 and `flush`=0: `pc_advance`=1 combinationally in that cycle; on the edge, `instr_valid`<=0, `fetch_count`+=1 (wraps modulo 2^CNT_W), then capture `pc_in` on the next edge -> REQ.
  - flush in HOLD (stall or not): `instr_valid`<=0, no `pc_advance`, no count, recapture `pc_in`.
- DROP: wait for `mem_rvalid`, discard data, then recapture `pc_in`. Further flushes in DROP have no effect.
- ERR: absorbing; `mem_req`=0, `instr_valid`=0, `pc_advance`=0. Exit only via reset.
- `pc_advance` is never 1 outside HOLD and is never high for two consecutive cycles.
- `mem_rvalid` outside WAIT/DROP is ignored.
- Timing:
  - Minimum latency is 3 edges from capture to `instr_valid` (gnt immediate, rvalid next cycle).
  - Steady-state throughput is one instruction per 4 cycles with a zero-wait memory.
  - The PC register updates on the falling edge after `pc_advance`, so the following rising-edge capture sees the new PC.

Test Plan:
1. Reset release, `pc_in`=0x00400020, `mem_gnt` tied 1, rvalid one cycle after gnt with rdata=0x8C010004 -> `mem_addr`=0x00400020; `instr_valid`=1 exactly 3 edges after capture, `instr_out`=0x8C010004, `instr_pc`=0x00400020; `pc_advance` one cycle; `fetch_count`=1.
2. `stall_in`=1 for 5 cycles in HOLD -> `instr_out`/`instr_valid` stable; `pc_advance`=0 throughout, then single pulse on release; count increments once.
3. flush asserted in WAIT, rvalid 2 cycles later with 0xDEADBEEF -> 0xDEADBEEF never appears on `instr_out`; next `mem_addr` equals the new `pc_in`=0x00400040.
4. flush coincident with `mem_rvalid` and separately coincident with `mem_gnt` -> no `instr_valid`, correct DROP/recapture, one request per redirect.
5. `pc_in`=0x00400022 at capture -> `fetch_err`=1, `mem_req` stays 0 forever; `rst_n` pulse clears `fetch_err` and restarts from IDLE.
6. `rst_n` asserted mid-WAIT and `fetch_count` preloaded to 0xFFFF via 65535 fetches -> all outputs at reset values asynchronously; counter wraps 0xFFFF -> 0x0000.

Source files
------------

// File: rtl/ifetch_unit_if.sv
// Instruction-memory read port: request/grant handshake plus a separate response strobe.
// master = fetch unit (drives request and address), slave = instruction memory.
interface ifetch_unit_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_gnt,
    input  mem_rvalid,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_gnt,
    output mem_rvalid,
    output mem_rdata
  );
endinterface

// File: rtl/ifetch_unit.sv
// Fetch stage: captures the PC, reads imem over req/gnt/rvalid and holds the word for decode.
// Capture-to-valid is 3 edges; stall_in freezes the held word, pc_advance pulses once on acceptance.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0020,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  ifetch_unit_if.master    mem,
  input  logic [31:0]      pc_in,
  input  logic             flush,
  output logic [31:0]      instr_out,
  output logic [31:0]      instr_pc,
  output logic             instr_valid,
  input  logic             stall_in,
  output logic             pc_advance,
  output logic             fetch_err,
  output logic [CNT_W-1:0] fetch_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DROP,
    S_ERR
  } state_t;

  state_t             state_q, state_d;
  logic               mem_req_q, mem_req_d;
  logic [31:0]        mem_addr_q, mem_addr_d;
  logic [31:0]        instr_q, instr_d;
  logic [31:0]        ipc_q, ipc_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               pc_misaligned;

  assign pc_misaligned = |pc_in[1:0];

  always_comb begin
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    instr_d    = instr_q;
    ipc_d      = ipc_q;
    valid_d    = valid_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    pc_advance = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (pc_misaligned) begin
          err_d   = 1'b1;
          state_d = S_ERR;
        end else begin
          mem_addr_d = pc_in;
          mem_req_d  = 1'b1;
          state_d    = S_REQ;
        end
      end

      S_REQ: begin
        if (mem.mem_gnt) begin
          mem_req_d = 1'b0;
          state_d   = flush ? S_DROP : S_WAIT;
        end else if (flush) begin
          // Redirect before acceptance: retarget the pending request in place.
          if (pc_misaligned) begin
            mem_req_d = 1'b0;
            err_d     = 1'b1;
            state_d   = S_ERR;
          end else begin
            mem_addr_d = pc_in;
          end
        end
      end

      S_WAIT: begin
        if (mem.mem_rvalid) begin
          if (flush) begin
            state_d = S_IDLE;
          end else begin
            instr_d = mem.mem_rdata;
            ipc_d   = mem_addr_q;
            valid_d = 1'b1;
            state_d = S_HOLD;
          end
        end else if (flush) begin
          state_d = S_DROP;
        end
      end

      S_HOLD: begin
        if (flush) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end else if (!stall_in) begin
          pc_advance = 1'b1;
          valid_d    = 1'b0;
          cnt_d      = cnt_q + 1'b1;
          state_d    = S_IDLE;
        end
      end

      // Response owed to a flushed request; swallow it before fetching again.
      S_DROP: begin
        if (mem.mem_rvalid) begin
          state_d = S_IDLE;
        end
      end

      S_ERR: begin
        state_d = S_ERR;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= RESET_PC;
      instr_q    <= '0;
      ipc_q      <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      instr_q    <= instr_d;
      ipc_q      <= ipc_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign mem.mem_req  = mem_req_q;
  assign mem.mem_addr = mem_addr_q;
  assign instr_out    = instr_q;
  assign instr_pc     = ipc_q;
  assign instr_valid  = valid_q;
  assign fetch_err    = err_q;
  assign fetch_count  = cnt_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: a small memory responder plus hand-computed expectations.
// The counter is built 4 bits wide here so its wrap is reachable in a handful of fetches.
module tb_ifetch_unit;

  localparam logic [31:0] RST_PC = 32'h0040_0020;
  localparam int          CW     = 4;

  logic          clk;
  logic          rst_n;
  logic [31:0]   pc_in;
  logic          flush;
  logic          stall_in;
  logic [31:0]   instr_out;
  logic [31:0]   instr_pc;
  logic          instr_valid;
  logic          pc_advance;
  logic          fetch_err;
  logic [CW-1:0] fetch_count;

  ifetch_unit_if bus ();

  ifetch_unit #(
    .RESET_PC (RST_PC),
    .CNT_W    (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem         (bus),
    .pc_in       (pc_in),
    .flush       (flush),
    .instr_out   (instr_out),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .stall_in    (stall_in),
    .pc_advance  (pc_advance),
    .fetch_err   (fetch_err),
    .fetch_count (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_gnt    = 0;
  int          rv_delay = 1;
  int          rv_cnt   = 0;
  int          gb       = 0;
  logic [31:0] rdata_nxt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One clock: memory answers rv_delay cycles after each grant, then this cycle's stall/flush.
  task automatic tick(input logic st, input logic fl);
    logic granted;
    granted = bus.mem_req && bus.mem_gnt;
    @(posedge clk);
    #1;
    if (granted) begin
      n_gnt++;
      rv_cnt = rv_delay;
    end
    bus.mem_rvalid = 1'b0;
    if (rv_cnt > 0) begin
      rv_cnt--;
      if (rv_cnt == 0) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = rdata_nxt;
      end
    end
    stall_in = st;
    flush    = fl;
    #1;
  endtask

  task automatic do_fetch(input logic [31:0] pc, input logic [31:0] data);
    pc_in     = pc;
    rdata_nxt = data;
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    check_eq("loop_instr", instr_out, data);
    tick(1'b0, 1'b0);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_req"},   32'(bus.mem_req), 32'd0);
    check_eq({tag, "_addr"},  bus.mem_addr, RST_PC);
    check_eq({tag, "_instr"}, instr_out, 32'd0);
    check_eq({tag, "_ipc"},   instr_pc, 32'd0);
    check_eq({tag, "_vld"},   32'(instr_valid), 32'd0);
    check_eq({tag, "_adv"},   32'(pc_advance), 32'd0);
    check_eq({tag, "_err"},   32'(fetch_err), 32'd0);
    check_eq({tag, "_cnt"},   32'(fetch_count), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end of the test");
    $fatal(1);
  end

  initial begin
    rst_n          = 1'b0;
    pc_in          = RST_PC;
    flush          = 1'b0;
    stall_in       = 1'b0;
    bus.mem_gnt    = 1'b1;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'd0;
    rdata_nxt      = 32'd0;

    // Reset state
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    check_reset_vals("rst");
    rst_n = 1'b1;

    // 1: minimum-latency fetch
    rdata_nxt = 32'h8C01_0004;
    tick(1'b0, 1'b0);
    check_eq("t1_req_e0",  32'(bus.mem_req), 32'd1);
    check_eq("t1_addr_e0", bus.mem_addr, 32'h0040_0020);
    check_eq("t1_vld_e0",  32'(instr_valid), 32'd0);
    tick(1'b0, 1'b0);
    check_eq("t1_req_e1",  32'(bus.mem_req), 32'd0);
    check_eq("t1_vld_e1",  32'(instr_valid), 32'd0);
    tick(1'b0, 1'b0);
    check_eq("t1_vld_e2",  32'(instr_valid), 32'd1);
    check_eq("t1_instr",   instr_out, 32'h8C01_0004);
    check_eq("t1_ipc",     instr_pc, 32'h0040_0020);
    check_eq("t1_adv",     32'(pc_advance), 32'd1);
    pc_in = 32'h0040_0024;
    tick(1'b0, 1'b0);
    check_eq("t1_adv_off", 32'(pc_advance), 32'd0);
    check_eq("t1_vld_off", 32'(instr_valid), 32'd0);
    check_eq("t1_cnt",     32'(fetch_count), 32'd1);

    // 2: five stalled cycles in HOLD
    rdata_nxt = 32'h0000_0013;
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    check_eq("t2_vld",     32'(instr_valid), 32'd1);
    check_eq("t2_adv",     32'(pc_advance), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 1'b0);
      check_eq("t2_vld_stall",   32'(instr_valid), 32'd1);
      check_eq("t2_instr_stall", instr_out, 32'h0000_0013);
      check_eq("t2_adv_stall",   32'(pc_advance), 32'd0);
    end
    check_eq("t2_cnt_stall", 32'(fetch_count), 32'd1);
    tick(1'b0, 1'b0);
    check_eq("t2_adv_rel", 32'(pc_advance), 32'd1);
    pc_in = 32'h0040_0028;
    tick(1'b0, 1'b0);
    check_eq("t2_adv_once", 32'(pc_advance), 32'd0);
    check_eq("t2_cnt",      32'(fetch_count), 32'd2);

    // 3: flush in WAIT, stale data two cycles later
    rdata_nxt = 32'hDEAD_BEEF;
    rv_delay  = 3;
    tick(1'b0, 1'b0);
    check_eq("t3_addr", bus.mem_addr, 32'h0040_0028);
    tick(1'b0, 1'b1);
    pc_in = 32'h0040_0040;
    tick(1'b0, 1'b1);
    check_eq("t3_vld_drop", 32'(instr_valid), 32'd0);
    tick(1'b0, 1'b0);
    check_eq("t3_rvalid_seen", 32'(bus.mem_rvalid), 32'd1);
    tick(1'b0, 1'b0);
    check_eq("t3_vld_after", 32'(instr_valid), 32'd0);
    check_eq("t3_no_stale",  instr_out, 32'h0000_0013);
    rv_delay  = 1;
    rdata_nxt = 32'h00A0_0093;
    tick(1'b0, 1'b0);
    check_eq("t3_readdr", bus.mem_addr, 32'h0040_0040);
    check_eq("t3_rereq",  32'(bus.mem_req), 32'd1);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    check_eq("t3_instr", instr_out, 32'h00A0_0093);
    check_eq("t3_ipc",   instr_pc, 32'h0040_0040);
    pc_in = 32'h0040_0044;
    tick(1'b0, 1'b0);
    check_eq("t3_cnt", 32'(fetch_count), 32'd3);

    // 4a: flush coincident with rvalid
    rdata_nxt = 32'h1111_1111;
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    pc_in = 32'h0040_0080;
    gb    = n_gnt;
    tick(1'b0, 1'b0);
    check_eq("t4a_vld",   32'(instr_valid), 32'd0);
    check_eq("t4a_instr", instr_out, 32'h00A0_0093);
    check_eq("t4a_req",   32'(bus.mem_req), 32'd0);

    // 4b: flush coincident with gnt
    tick(1'b0, 1'b1);
    check_eq("t4a_readdr", bus.mem_addr, 32'h0040_0080);
    pc_in     = 32'h0040_00C0;
    rdata_nxt = 32'h2222_2222;
    tick(1'b0, 1'b0);
    check_eq("t4b_req_drop", 32'(bus.mem_req), 32'd0);
    tick(1'b0, 1'b0);
    check_eq("t4b_vld",   32'(instr_valid), 32'd0);
    check_eq("t4b_instr", instr_out, 32'h00A0_0093);
    rdata_nxt = 32'h3333_3333;
    tick(1'b0, 1'b0);
    check_eq("t4b_readdr", bus.mem_addr, 32'h0040_00C0);
    check_eq("t4b_grants", 32'(n_gnt - gb), 32'd1);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    check_eq("t4b_instr_ok", instr_out, 32'h3333_3333);
    check_eq("t4b_ipc",      instr_pc, 32'h0040_00C0);
    tick(1'b1, 1'b1);
    check_eq("t4b_hold_flush_adv", 32'(pc_advance), 32'd0);
    pc_in = 32'h0040_0022;
    tick(1'b0, 1'b0);
    check_eq("t4b_hold_flush_vld", 32'(instr_valid), 32'd0);
    check_eq("t4b_hold_flush_cnt", 32'(fetch_count), 32'd3);

    // 5: misaligned capture is absorbing until reset
    tick(1'b0, 1'b0);
    check_eq("t5_err", 32'(fetch_err), 32'd1);
    check_eq("t5_req", 32'(bus.mem_req), 32'd0);
    pc_in = RST_PC;
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'(i % 2));
      check_eq("t5_req_err", 32'(bus.mem_req), 32'd0);
      check_eq("t5_err_sticky", 32'(fetch_err), 32'd1);
    end
    rst_n = 1'b0;
    #1;
    check_eq("t5_err_clr", 32'(fetch_err), 32'd0);
    check_eq("t5_addr_rst", bus.mem_addr, RST_PC);
    tick(1'b0, 1'b0);
    rst_n     = 1'b1;
    rdata_nxt = 32'h4444_4444;
    tick(1'b0, 1'b0);
    check_eq("t5_restart_req",  32'(bus.mem_req), 32'd1);
    check_eq("t5_restart_addr", bus.mem_addr, RST_PC);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    check_eq("t5_restart_instr", instr_out, 32'h4444_4444);
    tick(1'b0, 1'b0);
    check_eq("t5_restart_cnt", 32'(fetch_count), 32'd1);

    // 6: counter wrap, then async reset in the middle of WAIT
    for (int i = 0; i < 14; i++) begin
      do_fetch(32'h0040_0100 + 32'(i * 4), 32'h0000_1000 + 32'(i));
    end
    check_eq("t6_cnt_max", 32'(fetch_count), 32'd15);
    do_fetch(32'h0040_0180, 32'h0000_2000);
    check_eq("t6_cnt_wrap", 32'(fetch_count), 32'd0);
    do_fetch(32'h0040_0184, 32'h0000_2001);
    check_eq("t6_cnt_one", 32'(fetch_count), 32'd1);

    pc_in     = 32'h0040_0200;
    rv_delay  = 3;
    rdata_nxt = 32'h5555_5555;
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("t6_async");
    tick(1'b0, 1'b0);
    rst_n = 1'b1;
    tick(1'b0, 1'b0);
    rdata_nxt = 32'h6666_6666;
    check_eq("t6_stale_ignored", 32'(instr_valid), 32'd0);
    tick(1'b0, 1'b0);
    check_eq("t6_wait_vld", 32'(instr_valid), 32'd0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    check_eq("t6_instr", instr_out, 32'h6666_6666);
    check_eq("t6_ipc",   instr_pc, 32'h0040_0200);
    check_eq("t6_vld",   32'(instr_valid), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
